// File: rtl/ex_branch_resolve.sv
// EX-stage branch resolution: in-order queue of IF predictions, resolved against EX outcomes,
// producing registered predictor feedback and mispredict redirects. Optional BRANCH_STATS_EN adds counters.
module ex_branch_resolve #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        if_push,
   input  logic [31:0] if_pc,
   input  logic        if_pred_take,
   input  logic [31:0] if_pred_target,
   output logic        if_full,
   input  logic        ex_resolve,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   output logic        pc_jmp_feedback,
   output logic        pc_jmp_take,
   output logic [31:0] pc_stash_base,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic        order_err
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0] stat_branches,
   output logic [31:0] stat_mispredicts
`endif
);

   localparam logic [PTR_W:0]   LP_FULL    = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   LP_CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] LP_PTR_ONE = PTR_W'(1);

   logic [31:0]      r_pc_mem   [DEPTH];
   logic             r_take_mem [DEPTH];
   logic [31:0]      r_tgt_mem  [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             r_shadow;

   logic [31:0] w_head_pc;
   logic        w_head_take;
   logic [31:0] w_head_tgt;
   logic        w_empty;
   logic        w_resolve;
   logic        w_pc_match;
   logic        w_order_err;
   logic        w_pop;
   logic        w_mis;
   logic        w_push;

   assign if_full     = (r_count == LP_FULL);
   assign w_empty     = (r_count == '0);
   assign w_head_pc   = r_pc_mem[r_rd_ptr];
   assign w_head_take = r_take_mem[r_rd_ptr];
   assign w_head_tgt  = r_tgt_mem[r_rd_ptr];
   // A resolve in the cycle after a mispredict belongs to the wrong path and is dropped silently.
   assign w_resolve   = ex_resolve & ~r_shadow;
   assign w_pc_match  = (ex_pc == w_head_pc);
   assign w_order_err = w_resolve & (w_empty | ~w_pc_match);
   assign w_pop       = w_resolve & ~w_empty & w_pc_match;
   assign w_mis       = w_pop & ((w_head_take != ex_taken) |
                                 (w_head_take & ex_taken & (w_head_tgt != ex_target)));
   assign w_push      = if_push & ~if_full;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]   <= if_pc;
         r_take_mem[r_wr_ptr] <= if_pred_take;
         r_tgt_mem[r_wr_ptr]  <= if_pred_target;
      end
   end

   // A mispredict flushes everything, so a same-cycle push never advances the write pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_shadow <= 1'b0;
      end else begin
         r_shadow <= w_mis;
         if (w_mis) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + LP_CNT_ONE;
               2'b01:   r_count <= r_count - LP_CNT_ONE;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_jmp_feedback <= 1'b0;
         pc_jmp_take     <= 1'b0;
         pc_stash_base   <= '0;
         mispredict      <= 1'b0;
         redirect_pc     <= '0;
         order_err       <= 1'b0;
      end else begin
         pc_jmp_feedback <= w_pop;
         mispredict      <= w_mis;
         order_err       <= w_order_err;
         if (w_pop) begin
            pc_jmp_take   <= ex_taken;
            pc_stash_base <= w_head_pc;
         end
         if (w_mis) redirect_pc <= ex_taken ? ex_target : (ex_pc + 32'd4);
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (w_pop) stat_branches    <= stat_branches + 32'd1;
         if (w_mis) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Directed bench for ex_branch_resolve: queue model computes expected feedback per cycle,
// expected results go through exp_q and are compared one cycle later.
module tb_ex_branch_resolve;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_push = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_pred_take = 1'b0;
  logic [31:0] if_pred_target = '0;
  logic        if_full;
  logic        ex_resolve = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        pc_jmp_feedback;
  logic        pc_jmp_take;
  logic [31:0] pc_stash_base;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        order_err;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  ex_branch_resolve dut (
    .clk(clk), .reset_n(reset_n),
    .if_push(if_push), .if_pc(if_pc), .if_pred_take(if_pred_take),
    .if_pred_target(if_pred_target), .if_full(if_full),
    .ex_resolve(ex_resolve), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .pc_jmp_feedback(pc_jmp_feedback), .pc_jmp_take(pc_jmp_take),
    .pc_stash_base(pc_stash_base), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .order_err(order_err)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic        take;
    logic [31:0] tgt;
  } ent_t;

  ent_t        m_q[$];
  logic        m_shadow = 1'b0;
  logic        m_take = 1'b0;
  logic [31:0] m_stash = '0;
  logic [31:0] m_redir = '0;
  int          m_br = 0;
  int          m_mp = 0;
  // {feedback, take, stash[31:0], mispredict, redirect[31:0], order_err}
  logic [67:0] exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    if_push = 1'b0; if_pc = '0; if_pred_take = 1'b0; if_pred_target = '0;
    ex_resolve = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b0;
    #2;
    check("rst_if_full", {31'd0, if_full}, 32'd0);
    check("rst_feedback", {31'd0, pc_jmp_feedback}, 32'd0);
    check("rst_take", {31'd0, pc_jmp_take}, 32'd0);
    check("rst_stash", pc_stash_base, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    check("rst_order_err", {31'd0, order_err}, 32'd0);
`ifdef BRANCH_STATS_EN
    check("rst_stat_br", stat_branches, 32'd0);
    check("rst_stat_mp", stat_mispredicts, 32'd0);
`endif
    m_q.delete(); exp_q.delete();
    m_shadow = 1'b0; m_take = 1'b0; m_stash = '0; m_redir = '0; m_br = 0; m_mp = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock: drive push/resolve, predict with the model, compare registered outputs after the edge.
  task automatic cycle(input logic push, input logic [31:0] pc, input logic ptake,
                       input logic [31:0] ptgt, input logic res, input logic [31:0] epc,
                       input logic etaken, input logic [31:0] etgt);
    logic eff, ord, pop, mis, push_ok;
    logic [67:0] e;
    ent_t ent;
    @(negedge clk);
    if_push = push; if_pc = pc; if_pred_take = ptake; if_pred_target = ptgt;
    ex_resolve = res; ex_pc = epc; ex_taken = etaken; ex_target = etgt;
    #1;
    check("if_full", {31'd0, if_full}, {31'd0, m_q.size() == DEPTH});
    push_ok = push && (m_q.size() < DEPTH);
    eff = res && !m_shadow;
    ord = 1'b0; pop = 1'b0; mis = 1'b0;
    if (eff) begin
      if (m_q.size() == 0 || epc != m_q[0].pc) ord = 1'b1;
      else pop = 1'b1;
    end
    if (pop) begin
      mis = (m_q[0].take != etaken) || (m_q[0].take && etaken && (m_q[0].tgt != etgt));
      m_take = etaken;
      m_stash = m_q[0].pc;
      m_br++;
    end
    if (mis) begin
      m_redir = etaken ? etgt : epc + 32'd4;
      m_mp++;
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push_ok) begin
        ent.pc = pc; ent.take = ptake; ent.tgt = ptgt;
        m_q.push_back(ent);
      end
    end
    m_shadow = mis;
    exp_q.push_back({pop, m_take, m_stash, mis, m_redir, ord});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("feedback", {31'd0, pc_jmp_feedback}, {31'd0, e[67]});
    check("jmp_take", {31'd0, pc_jmp_take}, {31'd0, e[66]});
    check("stash_base", pc_stash_base, e[65:34]);
    check("mispredict", {31'd0, mispredict}, {31'd0, e[33]});
    check("redirect_pc", redirect_pc, e[32:1]);
    check("order_err", {31'd0, order_err}, {31'd0, e[0]});
    clear_inputs();
  endtask

  task automatic push_only(input logic [31:0] pc, input logic ptake, input logic [31:0] ptgt);
    cycle(1'b1, pc, ptake, ptgt, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic resolve_only(input logic [31:0] epc, input logic etaken, input logic [31:0] etgt);
    cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, epc, etaken, etgt);
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] pcs [4];
    logic        tks [4];
    logic [31:0] tgs [4];
    logic [31:0] pcv;

    do_reset();

    // 1: correctly predicted taken branch
    push_only(32'h100, 1'b1, 32'h200);
    resolve_only(32'h100, 1'b1, 32'h200);
    check("t1_stash_const", pc_stash_base, 32'h100);
    idle();

    // 2: predicted taken, actually not taken; then PC wrap of the fall-through
    push_only(32'h104, 1'b1, 32'h300);
    resolve_only(32'h104, 1'b0, 32'h0);
    check("t2_redirect_const", redirect_pc, 32'h108);
    idle();
    push_only(32'hFFFF_FFFC, 1'b1, 32'h10);
    resolve_only(32'hFFFF_FFFC, 1'b0, 32'h0);
    check("t2_wrap_redirect", redirect_pc, 32'h0);
    idle();

    // 3: target mismatch flushes younger entries and a same-cycle push; shadow drops next resolve
    push_only(32'h10, 1'b1, 32'h1000);
    push_only(32'h20, 1'b1, 32'h2000);
    push_only(32'h30, 1'b1, 32'h3000);
    cycle(1'b1, 32'h38, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 32'h1004);
    check("t3_redirect_const", redirect_pc, 32'h1004);
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h2000);
    resolve_only(32'h40, 1'b0, 32'h0);
    resolve_only(32'h38, 1'b0, 32'h0);

    // 4: fill, push+resolve while full drops the push, then wrap pointers over 3 fills
    push_only(32'hA00, 1'b0, 32'h0);
    push_only(32'hA04, 1'b0, 32'h0);
    push_only(32'hA08, 1'b0, 32'h0);
    push_only(32'hA0C, 1'b0, 32'h0);
    cycle(1'b1, 32'h999, 1'b0, 32'h0, 1'b1, 32'hA00, 1'b0, 32'h0);
    resolve_only(32'hA04, 1'b0, 32'h0);
    resolve_only(32'hA08, 1'b0, 32'h0);
    resolve_only(32'hA0C, 1'b0, 32'h0);
    resolve_only(32'h999, 1'b0, 32'h0);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        pcs[k] = $urandom & 32'hFFFF_FFFC;
        tks[k] = 1'($urandom_range(0, 1));
        tgs[k] = $urandom;
        push_only(pcs[k], tks[k], tgs[k]);
      end
      for (int k = 0; k < 4; k++) resolve_only(pcs[k], tks[k], tgs[k]);
    end

    // 5: order errors, then reset mid-stream clears outputs and queue
    resolve_only(32'h500, 1'b0, 32'h0);
    push_only(32'h500, 1'b0, 32'h0);
    resolve_only(32'h504, 1'b0, 32'h0);
    resolve_only(32'h500, 1'b0, 32'h0);
    push_only(32'h600, 1'b0, 32'h0);
    push_only(32'h604, 1'b1, 32'h900);
    resolve_only(32'h600, 1'b1, 32'h700);
    do_reset();
    resolve_only(32'h604, 1'b1, 32'h900);

`ifdef BRANCH_STATS_EN
    // 6: ten resolves, three of them mispredicted
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pcv = 32'h700 + 32'(i) * 32'd8;
      push_only(pcv, 1'b1, 32'h800);
      resolve_only(pcv, 1'b1, (i == 2 || i == 5 || i == 8) ? 32'h804 : 32'h800);
    end
    idle();
    check("stat_branches", stat_branches, 32'd10);
    check("stat_mispredicts", stat_mispredicts, 32'd3);
    check("stat_br_model", stat_branches, 32'(m_br));
    check("stat_mp_model", stat_mispredicts, 32'(m_mp));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
